// File: rtl/p_sa_tgl_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : p_sa_tgl_hs_pkg
// Purpose : Shared types and limits for the two-phase toggle handshake
//           crossing. It holds the receiver state encoding and the legal
//           synchronizer depth range. It also provides a helper used for the
//           elaboration-time depth check.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package p_sa_tgl_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // True when a synchronizer depth lies inside the supported range.
  function automatic bit sync_stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/p_sa_sync_chain.sv
`default_nettype none
// ============================================================================
// Module  : p_sa_sync_chain
// Purpose : Multi-flop synchronizer for a single asynchronous bit. The
//           source-side acknowledge path uses the same block.
// Ports   : clk   - sampling clock
//           rst_n - synchronous active-low reset, clears every stage
//           d     - asynchronous input bit
//           q     - synchronized output (last stage)
// Params  : STAGES - number of flops, at least SYNC_STAGES_MIN
// Revision: 1.0 - initial release
// ============================================================================
module p_sa_sync_chain
  import p_sa_tgl_hs_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
      $error("p_sa_sync_chain: STAGES=%0d below minimum %0d", STAGES, SYNC_STAGES_MIN);
    end
  endgenerate

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/p_sa_tgl_hs_rx.sv
`default_nettype none
// ============================================================================
// Module  : p_sa_tgl_hs_rx
// Purpose : Destination end of a two-phase toggle handshake. The block
//           synchronizes REQ_TGL and captures the quasi-static SRC_DATA bus
//           when a new toggle is seen. It presents the word on a valid/ready
//           interface and flips ACK_TGL once the consumer takes the word.
// Ports   : DST_CLK  - destination clock
//           DST_CLRN - synchronous active-low reset
//           REQ_TGL  - request toggle (asynchronous)
//           SRC_DATA - source data, stable while a request is outstanding
//           DST_DATA - captured data
//           DST_VLD  - DST_DATA valid
//           DST_RDY  - consumer ready
//           ACK_TGL  - acknowledge toggle, straight from a flop
//           XFER_CNT - wrapping count of completed transfers
//           ERR/OVF  - sticky error flags, only with SA_TGL_HS_RX_ERRCHK_EN
// Config  : `define SA_TGL_HS_RX_ERRCHK_EN adds ERR (toggle seen while
//           holding) and OVF (transfer counter wrapped).
// Revision: 1.0 - initial release
// ============================================================================
module p_sa_tgl_hs_rx
  import p_sa_tgl_hs_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 3,
  parameter int CW          = 8
) (
  input  logic          DST_CLK,
  input  logic          DST_CLRN,
  input  logic          REQ_TGL,
  input  logic [DW-1:0] SRC_DATA,
  output logic [DW-1:0] DST_DATA,
  output logic          DST_VLD,
  input  logic          DST_RDY,
  output logic          ACK_TGL,
  output logic [CW-1:0] XFER_CNT
`ifdef SA_TGL_HS_RX_ERRCHK_EN
  ,
  output logic          ERR,
  output logic          OVF
`endif
);

  generate
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("p_sa_tgl_hs_rx: SYNC_STAGES=%0d outside %0d..%0d",
             SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
  endgenerate

  logic          w_req_sync;
  logic          r_req_prev;
  logic          w_tgl;
  state_t        r_state;
  state_t        w_state_nx;
  logic          w_capture;
  logic          w_handshake;
  logic [DW-1:0] r_data;
  logic          r_vld;
  logic          r_ack;
  logic [CW-1:0] r_cnt;

  p_sa_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (DST_CLK),
    .rst_n (DST_CLRN),
    .d     (REQ_TGL),
    .q     (w_req_sync)
  );

  // A pending request is any difference between the synchronized toggle and
  // the last one consumed. In HOLD it stays pending because r_req_prev only
  // moves on capture, so it is picked up on the first IDLE cycle afterwards.
  assign w_tgl = w_req_sync ^ r_req_prev;

  // State register
  always_ff @(posedge DST_CLK) begin
    if (!DST_CLRN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    w_state_nx  = r_state;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tgl) begin
          w_capture  = 1'b1;
          w_state_nx = HOLD;
        end
      end
      HOLD: begin
        if (DST_RDY) begin
          w_handshake = 1'b1;
          w_state_nx  = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Datapath. Capture and handshake are mutually exclusive by state.
  always_ff @(posedge DST_CLK) begin
    if (!DST_CLRN) begin
      r_req_prev <= 1'b0;
      r_data     <= '0;
      r_vld      <= 1'b0;
      r_ack      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_capture) begin
        r_data     <= SRC_DATA;
        r_req_prev <= w_req_sync;
        r_vld      <= 1'b1;
      end
      if (w_handshake) begin
        r_vld <= 1'b0;
        r_ack <= ~r_ack;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign DST_DATA = r_data;
  assign DST_VLD  = r_vld;
  assign ACK_TGL  = r_ack;
  assign XFER_CNT = r_cnt;

`ifdef SA_TGL_HS_RX_ERRCHK_EN
  logic r_err;
  logic r_ovf;

  always_ff @(posedge DST_CLK) begin
    if (!DST_CLRN) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if ((r_state == HOLD) && w_tgl) begin
        r_err <= 1'b1;
      end
      if (w_handshake && (r_cnt == {CW{1'b1}})) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ERR = r_err;
  assign OVF = r_ovf;
`endif

endmodule
`default_nettype wire
